osc_reset_ctrl: RTL and testbench
=================================

// Module: osc_reset_ctrl
// PURPOSE
//   On-chip clock and reset management: the oscillator, power-up reset and
//   global set/reset functions combined in one block.
//   - Divides the reference clock into the nominal system oscillator output.
//   - Holds a power-up reset for a fixed number of cycles.
//   - Distributes an active-low global reset (resetn convention) whose
//     deassertion is synchronous.
//   - Sits at the top level and feeds sys_clk/resetn consumers such as the
//     I2C device driver.
// PARAMETERS
//   OSC_DIV      2    reference-to-osc divide ratio; even, >= 2
//   PUR_CYCLES   16   sys_clk cycles power-up reset is held after reset release; >= 1
//   SYNC_STAGES  2    reset-deassert synchronizer depth; >= 2
// PORTS
//   sys_clk      in   1  reference clock (single clock domain)
//   reset        in   1  asynchronous, active-high reset (external GSR request)
//   stdby        in   1  oscillator standby request, high = stop osc
//   osc          out  1  divided oscillator clock, 50% duty
//   sedstdby     out  1  registered standby status
//   pur_active   out  1  high while power-up reset count is running
//   resetn       out  1  global active-low reset to downstream logic
// BEHAVIOUR
//   Reset values (reset=1, async):
//     osc=0, div counter=0, sedstdby=0, pur counter=0, pur_active=1,
//     sync chain=0, resetn=0.
//   Oscillator:
//     - Counter runs 0..OSC_DIV/2-1.
//     - On the wrap, osc toggles.
//     - Period = OSC_DIV sys_clk cycles. First rising edge of osc appears
//       OSC_DIV/2 cycles after reset release.
//   Standby:
//     - sedstdby <= stdby, 1-cycle latency.
//     - While sedstdby=1, osc is forced low at its next falling toggle point
//       (never truncates a high phase), and the counter holds at 0.
//     - On sedstdby falling, osc resumes with a full low phase of OSC_DIV/2
//       cycles.
//     - stdby toggling mid high-phase: high phase completes normally.
//   Power-up reset:
//     - pur counter increments each cycle while < PUR_CYCLES.
//     - pur_active = (count < PUR_CYCLES).
//     - Counter saturates at PUR_CYCLES; no wrap-around.
//   Global reset:
//     - Internal request rq = reset | pur_active.
//     - resetn asserts (goes 0) asynchronously with reset.
//     - The pur_active portion asserts via the sync chain.
//     - Deassert: chain shifts in 1 each cycle while ~rq. resetn = last stage.
//     - resetn rises SYNC_STAGES cycles after pur_active falls.
//     - Total latency from reset falling edge to resetn=1 is
//       PUR_CYCLES+SYNC_STAGES cycles.
//   Reset mid-operation:
//     - All state returns to reset values immediately.
//     - The PUR count restarts from 0 after release.
//     - A reset pulse shorter than one cycle still fully restarts the sequence.
//   Simultaneous reset and stdby: reset dominates; sedstdby=0 after release
//     until stdby is sampled.
//   No output glitches: osc, sedstdby and resetn are driven directly from flops.
// TESTING
//   1) reset=1 for 10 cycles, release:
//      - pur_active falls exactly 16 cycles after release.
//      - resetn rises 18 cycles after release.
//   2) OSC_DIV=4, stdby=0:
//      - osc period is 4 sys_clk cycles, duty 2/2.
//      - First osc rise is 2 cycles after release.
//   3) stdby=1 during osc high:
//      - osc finishes the high phase, then stays 0.
//      - sedstdby=1 one cycle after stdby.
//      - stdby=0: first osc rise OSC_DIV/2+1 cycles later.
//   4) reset pulsed at cycle 10 of the PUR count:
//      - resetn stays 0.
//      - pur_active re-runs the full 16 cycles from the new release.
//   5) reset pulse of less than one sys_clk period, asynchronous:
//      - resetn drops within the same delta.
//      - Full 18-cycle recovery follows.
//   6) Long run, 1e6 cycles:
//      - resetn stays 1 and the pur counter stays saturated.
//      - osc toggle count = 1e6/(OSC_DIV/2) ±1.

Source files
------------

// File: rtl/osc_reset_ctrl.sv
// osc_reset_ctrl: divides the reference clock into the system oscillator,
// times the power-up reset and distributes the global active-low reset
// with asynchronous assertion and synchronous deassertion.
module osc_reset_ctrl #(
   parameter int OSC_DIV     = 2,
   parameter int PUR_CYCLES  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic sys_clk,
   input  logic reset,
   input  logic stdby,
   output logic osc,
   output logic sedstdby,
   output logic pur_active,
   output logic resetn
);

   localparam int HALF  = OSC_DIV / 2;
   localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int PUR_W = $clog2(PUR_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
   localparam logic [PUR_W-1:0] PUR_MAX  = PUR_W'(PUR_CYCLES);

   logic [DIV_W-1:0]       div_cnt_r;
   logic [DIV_W-1:0]       div_cnt_nxt_s;
   logic                   osc_r;
   logic                   osc_nxt_s;
   logic                   sedstdby_r;
   logic [PUR_W-1:0]       pur_cnt_r;
   logic [PUR_W-1:0]       pur_cnt_nxt_s;
   logic                   pur_active_r;
   logic                   pur_active_nxt_s;
   logic                   rq_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic [SYNC_STAGES-1:0] sync_nxt_s;

   // Divider next state: standby only parks the oscillator once it is low,
   // so a high phase already in progress always completes.
   always_comb begin
      div_cnt_nxt_s = div_cnt_r;
      osc_nxt_s     = osc_r;
      if (sedstdby_r && !osc_r) begin
         div_cnt_nxt_s = {DIV_W{1'b0}};
         osc_nxt_s     = 1'b0;
      end else if (div_cnt_r == DIV_LAST) begin
         div_cnt_nxt_s = {DIV_W{1'b0}};
         osc_nxt_s     = ~osc_r;
      end else begin
         div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
         osc_nxt_s     = osc_r;
      end
   end

   // Divider counter and oscillator output flop.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         div_cnt_r <= {DIV_W{1'b0}};
         osc_r     <= 1'b0;
      end else begin
         div_cnt_r <= div_cnt_nxt_s;
         osc_r     <= osc_nxt_s;
      end
   end

   // Standby request registered once; also the status output.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         sedstdby_r <= 1'b0;
      end else begin
         sedstdby_r <= stdby;
      end
   end

   // Power-up counter next state: saturates at PUR_CYCLES, never wraps.
   always_comb begin
      pur_cnt_nxt_s = pur_cnt_r;
      if (pur_cnt_r < PUR_MAX) begin
         pur_cnt_nxt_s = pur_cnt_r + PUR_W'(1);
      end else begin
         pur_cnt_nxt_s = pur_cnt_r;
      end
      pur_active_nxt_s = (pur_cnt_nxt_s < PUR_MAX);
   end

   // Power-up counter and its registered active flag.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         pur_cnt_r    <= {PUR_W{1'b0}};
         pur_active_r <= 1'b1;
      end else begin
         pur_cnt_r    <= pur_cnt_nxt_s;
         pur_active_r <= pur_active_nxt_s;
      end
   end

   // Reset chain next state: clear while any request is pending, otherwise
   // shift ones towards the output stage.
   always_comb begin
      rq_s       = reset | pur_active_r;
      sync_nxt_s = sync_r;
      if (rq_s) begin
         sync_nxt_s = {SYNC_STAGES{1'b0}};
      end else begin
         sync_nxt_s = {sync_r[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // Reset synchronizer: external reset clears it immediately.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= sync_nxt_s;
      end
   end

   assign osc        = osc_r;
   assign sedstdby   = sedstdby_r;
   assign pur_active = pur_active_r;
   assign resetn     = sync_r[SYNC_STAGES-1];

endmodule

// File: tb/tb_osc_reset_ctrl.sv
// Directed bench for osc_reset_ctrl with OSC_DIV=4, PUR_CYCLES=16, SYNC_STAGES=2.
module tb_osc_reset_ctrl;

   logic sys_clk;
   logic reset;
   logic stdby;
   logic osc;
   logic sedstdby;
   logic pur_active;
   logic resetn;

   int n_checks;
   int n_pass;

   osc_reset_ctrl #(
      .OSC_DIV     (4),
      .PUR_CYCLES  (16),
      .SYNC_STAGES (2)
   ) dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .stdby      (stdby),
      .osc        (osc),
      .sedstdby   (sedstdby),
      .pur_active (pur_active),
      .resetn     (resetn)
   );

   // Reference clock, 10 time-unit period.
   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n active edges, then settle 1 unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Counts edges (from k0+1) until pur_active falls and resetn rises.
   task automatic measure(input string tag, input int k0);
      int pf;
      int rr;
      pf = 0;
      rr = 0;
      for (int k = k0 + 1; k <= k0 + 40 && rr == 0; k++) begin
         step(1);
         if (!pur_active && pf == 0) pf = k;
         if (resetn && rr == 0) rr = k;
      end
      chk({tag, "_pur_fall"}, pf, 16);
      chk({tag, "_resetn_rise"}, rr, 18);
   endtask

   // Directed stimulus sequence.
   initial begin
      int pf;
      int rr;
      int first_rise;
      int osc_bad;
      int highs;
      int toggles;
      int rn_low;
      int pa_high;
      int cyc;
      logic osc_prev;

      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b0;
      stdby    = 1'b0;
      #1;
      // Reset asserted together with stdby: reset must dominate.
      reset = 1'b1;
      stdby = 1'b1;
      step(10);
      chk("rst_osc", int'(osc), 0);
      chk("rst_sedstdby", int'(sedstdby), 0);
      chk("rst_pur_active", int'(pur_active), 1);
      chk("rst_resetn", int'(resetn), 0);
      stdby = 1'b0;
      reset = 1'b0;

      // Test 1/2: PUR timing and oscillator waveform after release.
      pf = 0;
      rr = 0;
      first_rise = 0;
      osc_bad = 0;
      for (int k = 1; k <= 30; k++) begin
         step(1);
         if (!pur_active && pf == 0) pf = k;
         if (resetn && rr == 0) rr = k;
         if (osc && first_rise == 0) first_rise = k;
         if (int'(osc) != ((k / 2) % 2)) osc_bad++;
      end
      cyc = 30;
      chk("t1_pur_fall", pf, 16);
      chk("t1_resetn_rise", rr, 18);
      chk("t2_osc_first_rise", first_rise, 2);
      chk("t2_osc_pattern_errors", osc_bad, 0);

      // Test 3: stdby arrives one cycle before osc rises.
      step(3);
      cyc = cyc + 3;
      stdby = 1'b1;
      step(1);
      chk("t3_sedstdby_set", int'(sedstdby), 1);
      chk("t3_osc_rise", int'(osc), 1);
      step(1);
      chk("t3_osc_high_kept", int'(osc), 1);
      step(1);
      chk("t3_osc_fall", int'(osc), 0);
      highs = 0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (osc) highs++;
      end
      chk("t3_osc_parked_highs", highs, 0);
      stdby = 1'b0;
      step(1);
      chk("t3_sedstdby_clear", int'(sedstdby), 0);
      first_rise = 0;
      if (osc) first_rise = 1;
      for (int k = 2; k <= 12 && first_rise == 0; k++) begin
         step(1);
         if (osc) first_rise = k;
      end
      chk("t3_resume_rise", first_rise, 3);

      // Test 4: reset re-applied at cycle 10 of the PUR count.
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(10);
      chk("t4_pur_mid", int'(pur_active), 1);
      chk("t4_resetn_mid", int'(resetn), 0);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      measure("t4", 0);

      // Test 5: sub-cycle asynchronous reset pulse, with stdby requested.
      #2;
      reset = 1'b1;
      stdby = 1'b1;
      #1;
      chk("t5_async_resetn", int'(resetn), 0);
      chk("t5_async_pur", int'(pur_active), 1);
      chk("t5_async_osc", int'(osc), 0);
      #1;
      reset = 1'b0;
      chk("t5_sedstdby_after_release", int'(sedstdby), 0);
      step(1);
      chk("t5_sedstdby_sampled", int'(sedstdby), 1);
      stdby = 1'b0;
      measure("t5", 1);

      // Test 6: long run, oscillator toggles and reset stays released.
      step(5);
      toggles = 0;
      rn_low  = 0;
      pa_high = 0;
      osc_prev = osc;
      for (int k = 0; k < 2000; k++) begin
         step(1);
         if (osc != osc_prev) toggles++;
         osc_prev = osc;
         if (!resetn) rn_low++;
         if (pur_active) pa_high++;
      end
      chk("t6_osc_toggles_in_range", int'(toggles >= 999 && toggles <= 1001), 1);
      chk("t6_resetn_low_cycles", rn_low, 0);
      chk("t6_pur_active_cycles", pa_high, 0);
      chk("t6_pur_cnt_saturated", int'(dut.pur_cnt_r), 16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
